// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin selection among unit results, captured in a
// one-entry output register that stalls while the register-file port is busy.
module wb_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 3,
    localparam int UW        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_UNITS-1:0]            unit_done,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_rd,
    input  logic [NUM_UNITS*ID_WIDTH-1:0]   unit_id,
    output logic [NUM_UNITS-1:0]            unit_ack,
    output logic                            wb_valid,
    output logic [DATA_WIDTH-1:0]           wb_data,
    output logic [ID_WIDTH-1:0]             wb_id,
    output logic [UW-1:0]                   wb_unit,
    input  logic                            wb_ready
);

    logic [UW-1:0] ptr;
    logic [UW-1:0] ptr_nxt;
    logic [UW-1:0] grant_idx;
    logic          grant_valid;
    logic          can_load;
    logic          load;

    assign can_load = ~wb_valid | wb_ready;

    // Scan from the highest offset down so the last hit is the closest to ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            if (unit_done[(int'(ptr) + k) % NUM_UNITS]) begin
                grant_valid = 1'b1;
                grant_idx   = UW'((int'(ptr) + k) % NUM_UNITS);
            end
        end
    end

    // Ack is gated by rst_n so no unit sees its result accepted during reset.
    assign load = can_load & grant_valid & rst_n;

    always_comb begin
        unit_ack = '0;
        if (load) begin
            unit_ack[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_nxt = '0;
        if (NUM_UNITS > 1 && int'(grant_idx) != NUM_UNITS - 1) begin
            ptr_nxt = grant_idx + UW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_id    <= '0;
            wb_unit  <= '0;
        end else if (load) begin
            ptr      <= ptr_nxt;
            wb_valid <= 1'b1;
            wb_data  <= unit_rd[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            wb_id    <= unit_id[grant_idx*ID_WIDTH +: ID_WIDTH];
            wb_unit  <= grant_idx;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: 4-unit instance for the main sequence plus a
// 3-unit instance for the non-power-of-two wrap case.
module tb_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wb_ready;

    logic [3:0]   done4;
    logic [127:0] rd4;
    logic [11:0]  id4;
    logic [3:0]   ack4;
    logic         valid4;
    logic [31:0]  data4;
    logic [2:0]   wid4;
    logic [1:0]   unit4;

    logic [2:0]   done3;
    logic [95:0]  rd3;
    logic [8:0]   id3;
    logic [2:0]   ack3;
    logic         valid3;
    logic [31:0]  data3;
    logic [2:0]   wid3;
    logic [1:0]   unit3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.NUM_UNITS(4), .DATA_WIDTH(32), .ID_WIDTH(3)) u4 (
        .clk(clk), .rst_n(rst_n), .unit_done(done4), .unit_rd(rd4), .unit_id(id4),
        .unit_ack(ack4), .wb_valid(valid4), .wb_data(data4), .wb_id(wid4),
        .wb_unit(unit4), .wb_ready(wb_ready)
    );

    wb_arbiter #(.NUM_UNITS(3), .DATA_WIDTH(32), .ID_WIDTH(3)) u3 (
        .clk(clk), .rst_n(rst_n), .unit_done(done3), .unit_rd(rd3), .unit_id(id3),
        .unit_ack(ack3), .wb_valid(valid3), .wb_data(data3), .wb_id(wid3),
        .wb_unit(unit3), .wb_ready(wb_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [31:0] next_rd;
        logic [31:0] cons_exp;
        logic        rdy_pat [6];

        rst_n    = 1'b0;
        wb_ready = 1'b1;
        done4    = '0;
        rd4      = '0;
        id4      = '0;
        done3    = '0;
        rd3      = '0;
        id3      = '0;
        #2;
        chk("rst_valid", 32'(valid4), 32'h0);
        chk("rst_ack", 32'(ack4), 32'h0);
        #10;
        rst_n = 1'b1;
        cyc();

        // single result from unit 2
        done4 = 4'b0100;
        rd4[2*32 +: 32] = 32'h0000_00A5;
        id4[2*3 +: 3]   = 3'd3;
        #1;
        chk("single_ack", 32'(ack4), 32'h4);
        cyc();
        done4 = 4'b0000;
        #1;
        chk("single_valid", 32'(valid4), 32'h1);
        chk("single_data", data4, 32'hA5);
        chk("single_id", 32'(wid4), 32'h3);
        chk("single_unit", 32'(unit4), 32'h2);
        cyc();
        chk("single_drain", 32'(valid4), 32'h0);

        // wrap: ptr=3 with units 0 and 3 pending
        done4 = 4'b1001;
        #1;
        chk("wrap_ack3", 32'(ack4), 32'h8);
        cyc();
        done4 = 4'b0001;
        #1;
        chk("wrap_ack0", 32'(ack4), 32'h1);
        chk("wrap_unit3", 32'(unit4), 32'h3);
        cyc();
        done4 = 4'b0000;
        #1;
        chk("wrap_unit0", 32'(unit4), 32'h0);
        cyc();

        // async reset while holding a result and all units pending
        for (int i = 0; i < 4; i++) rd4[i*32 +: 32] = 32'h100 + 32'(i);
        done4 = 4'b1111;
        cyc();
        chk("pre_rst_valid", 32'(valid4), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid4), 32'h0);
        chk("arst_data", data4, 32'h0);
        chk("arst_ack", 32'(ack4), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // full contention, grant order 0,1,2,3,0,1
        for (int j = 0; j < 6; j++) begin
            chk("rr_ack", 32'(ack4), 32'h1 << (j % 4));
            cyc();
            chk("rr_unit", 32'(unit4), 32'(j % 4));
            chk("rr_data", data4, 32'h100 + 32'(j % 4));
        end

        // backpressure: register holds unit 1 result 0x101, ptr=2
        done4 = 4'b0010;
        rd4[1*32 +: 32] = 32'h1234;
        wb_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("bp_ack", 32'(ack4), 32'h0);
            chk("bp_data", data4, 32'h101);
            chk("bp_valid", 32'(valid4), 32'h1);
            cyc();
        end
        wb_ready = 1'b1;
        #1;
        chk("bp_release_ack", 32'(ack4), 32'h2);
        cyc();
        done4 = 4'b0000;
        #1;
        chk("bp_data_new", data4, 32'h1234);
        cyc();
        chk("bp_drain", 32'(valid4), 32'h0);

        // unit 0 streams with done held high, wb_ready toggling
        rdy_pat   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_valid = 1'b0;
        exp_data  = 32'h0;
        next_rd   = 32'h50;
        cons_exp  = 32'h50;
        done4     = 4'b0001;
        for (int j = 0; j < 6; j++) begin
            wb_ready = rdy_pat[j];
            rd4[31:0] = next_rd;
            #1;
            chk("strm_ack", 32'(ack4), 32'(!exp_valid || rdy_pat[j]));
            if (exp_valid && rdy_pat[j]) begin
                chk("strm_consumed", data4, cons_exp);
                cons_exp = cons_exp + 1;
            end
            cyc();
            if (!exp_valid || rdy_pat[j]) begin
                exp_valid = 1'b1;
                exp_data  = next_rd;
                next_rd   = next_rd + 1;
            end
            chk("strm_valid", 32'(valid4), 32'(exp_valid));
            chk("strm_data", data4, exp_data);
        end
        done4    = 4'b0000;
        wb_ready = 1'b1;
        cyc();

        // three units: after a grant to unit 2 the pointer wraps to 0
        done3 = 3'b100;
        #1;
        chk("n3_ack2", 32'(ack3), 32'h4);
        cyc();
        done3 = 3'b101;
        #1;
        chk("n3_ack0", 32'(ack3), 32'h1);
        chk("n3_unit2", 32'(unit3), 32'h2);
        cyc();
        #1;
        chk("n3_unit0", 32'(unit3), 32'h0);
        chk("n3_ack2b", 32'(ack3), 32'h4);
        done3 = 3'b000;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
